// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset release sequencer.
// Optional Ready synchroniser is enabled with RESET_SEQ_READY_SYNC_EN.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_NUM_STAGES     = 4;
    localparam int unsigned DEF_HOLD_CYCLES    = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // Wide enough for the larger terminal count plus one, so it can never wrap.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tmo);
        int unsigned m;
        m = (hold > tmo) ? hold : tmo;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ready_sync.sv
// Parameterised-width 2-flop synchroniser, cleared by the synchronous reset.
module ready_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases downstream stage resets in index order, gated on each stage's Ready.
// Define RESET_SEQ_READY_SYNC_EN to pass Ready through a 2-flop synchroniser.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic [NUM_STAGES-1:0] Ready,
    input  logic                  Restart,
    output logic [NUM_STAGES-1:0] StageReset,
    output logic                  Done,
    output logic                  Fault,
    output logic [IW-1:0]         FaultStage
);

    localparam int unsigned CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    logic [NUM_STAGES-1:0] ready_s;

`ifdef RESET_SEQ_READY_SYNC_EN
    ready_sync #(
        .WIDTH(NUM_STAGES)
    ) u_ready_sync (
        .Clk   (Clk),
        .nReset(nReset),
        .d_i   (Ready),
        .q_o   (ready_s)
    );
`else
    assign ready_s = Ready;
`endif

    seq_state_e            state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] sr_q, sr_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic [IW-1:0]         fs_q, fs_d;

    logic                  any_low, below_low, do_fault, do_hold;
    logic [IW-1:0]         low_all, low_below, fault_at;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= HOLD;
            count_q <= '0;
            idx_q   <= '0;
            sr_q    <= '1;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            fs_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        done_d    = done_q;
        fault_d   = fault_q;
        fs_d      = fs_q;
        any_low   = 1'b0;
        below_low = 1'b0;
        low_all   = '0;
        low_below = '0;
        do_fault  = 1'b0;
        do_hold   = 1'b0;
        fault_at  = '0;

        // Scan downwards so the lowest low index is the one left standing.
        for (int j = int'(NUM_STAGES) - 1; j >= 0; j--) begin
            if (!ready_s[j]) begin
                any_low = 1'b1;
                low_all = IW'(j);
                if (j < int'(idx_q)) begin
                    below_low = 1'b1;
                    low_below = IW'(j);
                end
            end
        end

        case (state_q)
            HOLD: begin
                if (count_q == HOLD_LAST) begin
                    sr_d[0] = 1'b0;
                    count_d = '0;
                    state_d = WAIT;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            WAIT: begin
                if (below_low) begin
                    do_fault = 1'b1;
                    fault_at = low_below;
                end else if (ready_s[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        count_d = '0;
                        for (int j = 0; j < int'(NUM_STAGES); j++) begin
                            if (j == int'(idx_q) + 1) sr_d[j] = 1'b0;
                        end
                    end
                end else if (count_q == TO_LAST) begin
                    do_fault = 1'b1;
                    fault_at = idx_q;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (any_low) begin
                    do_fault = 1'b1;
                    fault_at = low_all;
                end else if (Restart) begin
                    do_hold = 1'b1;
                end
            end
            FAULT: begin
                if (Restart) do_hold = 1'b1;
            end
            default: do_hold = 1'b1;
        endcase

        if (do_fault) begin
            fault_d = 1'b1;
            fs_d    = fault_at;
            sr_d    = '1;
            done_d  = 1'b0;
            state_d = FAULT;
        end
        if (do_hold) begin
            state_d = HOLD;
            count_d = '0;
            idx_d   = '0;
            sr_d    = '1;
            done_d  = 1'b0;
            fault_d = 1'b0;
            fs_d    = '0;
        end
    end

    assign StageReset = sr_q;
    assign Done       = done_q;
    assign Fault      = fault_q;
    assign FaultStage = fs_q;

endmodule
